// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC sequencer, single-outstanding imem fetch, 2-entry inst FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects trap into a HALT state.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic [63:0] inst_pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_live;
    logic [63:0] r_fetch_pc;
    logic [63:0] r_out_pc;
    logic [1:0]  r_count;
    logic [31:0] r_inst0;
    logic [31:0] r_inst1;
    logic [63:0] r_pc0;
    logic [63:0] r_pc1;
    logic [63:0] r_pc4_0;
    logic [63:0] r_pc4_1;

    logic        w_req_hs;
    logic        w_pop;
    logic        w_push;
    logic        w_redir;
    logic [63:0] w_tgt;
    logic [63:0] w_new_pc4;

    assign imem_req_valid = (r_state == S_REQ) && (r_count < 2'd2);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (r_count != 2'd0);
    assign w_pop          = inst_valid && inst_ready;
    assign w_push         = (r_state == S_WAIT) && imem_rsp_valid && !w_redir;
    assign w_new_pc4      = r_out_pc + 64'd4;

    assign inst           = r_inst0;
    assign inst_pc        = r_pc0;
    assign inst_pc_plus4  = r_pc4_0;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;
    logic w_bad;

    assign w_redir = redirect_valid && (r_state != S_IDLE)
                     && (r_state != S_HALT);
    assign w_tgt   = redirect_addr;
    assign w_bad   = w_redir && (redirect_addr[1:0] != 2'b00);
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_bad) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_redir = redirect_valid && (r_state != S_IDLE);
    assign w_tgt   = redirect_addr & ~64'h3;
    assign misalign_err = 1'b0;
`endif

    // a redirect in REQ keeps valid high; only the address moves
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_live) w_state_nx = S_REQ;
            end
            S_REQ: begin
                if (w_redir) w_state_nx = w_req_hs ? S_DROP : S_REQ;
                else if (w_req_hs) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_redir) w_state_nx = imem_rsp_valid ? S_REQ : S_DROP;
                else if (imem_rsp_valid) w_state_nx = S_REQ;
            end
            S_DROP: begin
                if (imem_rsp_valid) w_state_nx = S_REQ;
            end
            default: w_state_nx = r_state;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w_bad) w_state_nx = S_HALT;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_live     <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_out_pc   <= 64'd0;
        end else begin
            r_state <= w_state_nx;
            r_live  <= 1'b1;
            if (w_redir) r_fetch_pc <= w_tgt;
            else if (w_req_hs) r_fetch_pc <= r_fetch_pc + 64'd4;
            if (w_req_hs) r_out_pc <= r_fetch_pc;
        end
    end

    // entry 0 is the head; a pop shifts entry 1 down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_inst0 <= 32'd0;
            r_inst1 <= 32'd0;
            r_pc0   <= 64'd0;
            r_pc1   <= 64'd0;
            r_pc4_0 <= 64'd0;
            r_pc4_1 <= 64'd0;
        end else if (w_redir) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_inst0 <= r_inst1;
                r_pc0   <= r_pc1;
                r_pc4_0 <= r_pc4_1;
            end
            if (w_push) begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                    r_inst0 <= imem_rsp_data;
                    r_pc0   <= r_out_pc;
                    r_pc4_0 <= w_new_pc4;
                end else begin
                    r_inst1 <= imem_rsp_data;
                    r_pc1   <= r_out_pc;
                    r_pc4_1 <= w_new_pc4;
                end
            end
            if (w_push && !w_pop) r_count <= r_count + 2'd1;
            else if (!w_push && w_pop) r_count <= r_count - 2'd1;
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch front end for the single-issue RV64 core. It consumes the redirect requests produced by the jump and branch resolution units, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions in a 2-entry FIFO. Each instruction is delivered to decode with its own PC and PC+4. PC+4 is the `pc` operand convention used by the JAL, JALR and branch units, whose targets are computed as pc − 4 + imm.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `redirect_valid`  in  1  redirect request, single-cycle pulse from the jump/branch units (JAL, JALR, taken branch).
- `redirect_addr`  in  64  redirect target address.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  64  fetch address, 4-byte aligned.
- `imem_rsp_valid`  in  1  response valid; always accepted, no ready signal.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  buffered instruction available.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  64  address of `inst`.
- `inst_pc_plus4`  out  64  `inst_pc` + 4, modulo 2^64.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers:
  - `fetch_pc`: 64 bits.
  - FIFO: 2 entries of {inst, pc}, with a 2-bit count.
  - FSM state.
- Only one memory request is outstanding at any time. Memory responds in order with latency of at least 1 cycle.
- FSM states:
  - IDLE: the single cycle after reset release. Goes to REQ.
  - REQ: `imem_req_valid`=1 when count + outstanding < 2, with `imem_req_addr`=`fetch_pc`. On handshake, `fetch_pc` += 4 and the state goes to WAIT.
  - WAIT: on `imem_rsp_valid`, push {data, addr} to the FIFO and go to REQ.
  - DROP: wait for the stale response, discard it, then go to REQ.
  - HALT: only with the macro defined. No requests are issued. Exit only by reset.
- Redirect has top priority, in any state except IDLE and HALT. On `redirect_valid`:
  - `fetch_pc` ← `redirect_addr`.
  - The FIFO is flushed: count ← 0, and `inst_valid` falls next cycle.
  - From REQ with no handshake that cycle: stay in REQ. `imem_req_addr` changes while valid is held high; this is the only permitted address change under valid.
  - From REQ with a handshake that same cycle: go to DROP. The just-accepted request is stale.
  - From WAIT with no response that cycle: go to DROP.
  - From WAIT with a response in the same cycle: discard the response and go to REQ.
- Redirect in the same cycle as an `inst_valid`&`inst_ready` handshake: the handshake completes, then the remaining entries are flushed.
- FIFO push and pop in the same cycle: count is unchanged.
- Pushes never overflow, because requests are throttled by count + outstanding.
- All PC arithmetic is 64-bit and wraps modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous):
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_pc_plus4`=0.
  - `misalign_err`=0.
  - FSM=IDLE, count=0, `fetch_pc`=`RESET_PC`.
- First `imem_req_valid` is driven in the 2nd rising edge after `rst_n` deasserts (IDLE then REQ).
- Response in cycle N → `inst_valid` in cycle N+1 (FIFO outputs are registered).
- Redirect in cycle N → `imem_req_addr`=`redirect_addr` in cycle N+1 if the state is REQ.
- Best steady-state throughput with 1-cycle memory latency is one instruction per 2 cycles.
- Reset asserted mid-operation: all state clears immediately and in-flight responses are ignored. The memory is reset together with this block.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_addr[1:0]`≠0 sets `misalign_err`=1 in the next cycle. It stays set until reset.
  - The FSM goes to HALT and the FIFO is flushed.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_addr[1:0]` is forced to 0.
  - `misalign_err` is tied to 0.
  - The HALT state is not present.

## Test plan
- Reset, then `imem_req_ready`=1 with 1-cycle response latency:
  - Requests go to 0x8000_0000, 0x8000_0004, …
  - Decode sees `inst_pc`=0x8000_0000 with `inst_pc_plus4`=0x8000_0004.
- `inst_ready`=0 for 10 cycles: exactly 2 responses are buffered, `imem_req_valid` stays 0, and no data is lost when ready rises.
- Redirect to 0x8000_0100 while in WAIT:
  - The stale response is dropped.
  - The next request address is 0x8000_0100.
  - `inst_valid` is 0 until the new data arrives.
- Redirect in the same cycle as a request handshake: DROP is entered, and exactly one response is discarded.
- Redirect to 0x8000_0102:
  - With the macro defined, `misalign_err`=1 and no further requests are issued.
  - With the macro undefined, the next request address is 0x8000_0100.
- `fetch_pc` = 64'hFFFF_FFFF_FFFF_FFFC: the next request address is 0, and `inst_pc_plus4` for that word = 0.
